// File: rtl/imem_loader_if.sv
// Instruction-memory loader bus: fetch port, load control and byte stream.
interface imem_loader_if #(
  parameter int AW = 6
);
  logic [31:0] pc;
  logic [31:0] instr;
  logic        load_start;
  logic [AW:0] load_len;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        cpu_rst;
  logic        load_done;

  modport master (
    output pc, load_start, load_len, in_valid, in_data,
    input  instr, in_ready, cpu_rst, load_done
  );

  modport slave (
    input  pc, load_start, load_len, in_valid, in_data,
    output instr, in_ready, cpu_rst, load_done
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader for a 2**AW-word instruction memory: assembles a big-endian byte
// stream into words, then serves zero-latency fetches while holding the core in reset until done.
module imem_loader #(
  parameter int AW = 6
) (
  input logic           clk,
  input logic           rst,
  imem_loader_if.slave  bus
);
  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] DEPTH_L = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t        state, state_n;
  logic [AW:0]   len;
  logic [AW:0]   wcnt;
  logic [AW-1:0] waddr;
  logic [1:0]    bcnt;
  logic [23:0]   shreg;
  logic          done_q, done_n;
  logic [31:0]   mem [DEPTH];

  logic [AW:0]   len_clamp;
  logic          start_ok;
  logic          accept;
  logic          word_we;
  logic          last_word;
  logic          pc_hi_unused;

  // Only the low AW bits of pc address the memory; upper bits alias.
  assign pc_hi_unused = ^bus.pc[31:AW];

  assign len_clamp = (bus.load_len > DEPTH_L) ? DEPTH_L : bus.load_len;
  assign start_ok  = bus.load_start && (state == IDLE || state == RUN);
  assign accept    = (state == LOAD) && bus.in_valid;
  assign word_we   = accept && (bcnt == 2'd3);
  assign last_word = word_we && ((wcnt + 1'b1) == len);

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    unique case (state)
      IDLE, RUN: begin
        if (bus.load_start) begin
          // A zero-length load has nothing to stream; go straight to RUN.
          if (len_clamp == '0) begin
            state_n = RUN;
            done_n  = 1'b1;
          end else begin
            state_n = LOAD;
          end
        end
      end
      LOAD: begin
        if (last_word) begin
          state_n = RUN;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      len    <= '0;
      wcnt   <= '0;
      waddr  <= '0;
      bcnt   <= '0;
      shreg  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= done_n;
      if (start_ok) begin
        len   <= len_clamp;
        wcnt  <= '0;
        waddr <= '0;
        bcnt  <= '0;
      end else if (accept) begin
        bcnt  <= bcnt + 2'd1;
        shreg <= {shreg[15:0], bus.in_data};
        if (bcnt == 2'd3) begin
          waddr <= waddr + 1'b1;
          wcnt  <= wcnt + 1'b1;
        end
      end
    end
  end

  // Memory is deliberately not reset so a reload only touches the words it writes.
  always_ff @(posedge clk) begin
    if (word_we)
      mem[waddr] <= {shreg, bus.in_data};
  end

  assign bus.in_ready  = (state == LOAD);
  assign bus.cpu_rst   = (state != RUN);
  assign bus.load_done = done_q;
  assign bus.instr     = (state == RUN) ? mem[bus.pc[AW-1:0]] : 32'h0000_0000;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: load, gaps, zero length, reload, reset mid-load, clamp/alias.
module tb_imem_loader;
  localparam int AW = 6;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  imem_loader_if #(.AW(AW)) bus ();

  imem_loader #(.AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] pc;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_table();
    foreach (vt[i]) begin
      bus.pc = vt[i].pc;
      #1;
      chk(vt[i].nm, bus.instr, vt[i].exp);
    end
    vt.delete();
  endtask

  task automatic start_load(input logic [AW:0] n);
    bus.load_start = 1'b1;
    bus.load_len   = n;
    @(posedge clk); #1;
    bus.load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    if (gap) begin
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("gap_in_ready", {31'd0, bus.in_ready}, 32'd1);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] wgen(input int i);
    logic [7:0] a, c, d;
    a = 8'(i);
    c = 8'(255 - i);
    d = 8'(i * 7);
    return {a, 8'hA5, c, d};
  endfunction

  logic [7:0] prog [8];

  initial begin
    logic [31:0] w;
    checks = 0;
    errors = 0;
    prog[0] = 8'h20; prog[1] = 8'h08; prog[2] = 8'h00; prog[3] = 8'h05;
    prog[4] = 8'h8C; prog[5] = 8'h09; prog[6] = 8'h00; prog[7] = 8'h04;
    rst = 1'b1;
    bus.pc = '0; bus.load_start = 1'b0; bus.load_len = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_cpu_rst", {31'd0, bus.cpu_rst}, 32'd1);
    chk("rst_load_done", {31'd0, bus.load_done}, 32'd0);
    rst = 1'b0;

    // IDLE holds and consumes nothing without load_start
    bus.in_valid = 1'b1; bus.in_data = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("idle_cpu_rst", {31'd0, bus.cpu_rst}, 32'd1);
    end
    bus.in_valid = 1'b0;

    // Zero length: IDLE -> RUN next edge with one-cycle done
    start_load('0);
    chk("zl_done", {31'd0, bus.load_done}, 32'd1);
    chk("zl_cpu_rst", {31'd0, bus.cpu_rst}, 32'd0);
    chk("zl_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("zl_done_off", {31'd0, bus.load_done}, 32'd0);
    chk("zl_in_ready2", {31'd0, bus.in_ready}, 32'd0);

    // Reload from RUN with gapped stream
    start_load(7'd2);
    chk("gap_cpu_rst", {31'd0, bus.cpu_rst}, 32'd1);
    chk("gap_instr_nop", bus.instr, 32'h0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("gap_not_done", {31'd0, bus.load_done}, 32'd0);
      send_byte(prog[i], 1'b1);
    end
    chk("gap_done", {31'd0, bus.load_done}, 32'd1);
    chk("gap_run", {31'd0, bus.cpu_rst}, 32'd0);
    vt.push_back('{"gap_pc0", 32'h0, 32'h2008_0005});
    vt.push_back('{"gap_pc1", 32'h1, 32'h8C09_0004});
    vt.push_back('{"gap_pc40", 32'h40, 32'h2008_0005});
    vt.push_back('{"gap_pc41", 32'h41, 32'h8C09_0004});
    vt.push_back('{"gap_pcc1", 32'hFFFF_FFC1, 32'h8C09_0004});
    run_table();
    @(posedge clk); #1;
    chk("gap_done_off", {31'd0, bus.load_done}, 32'd0);

    // Reload of one zero word; load_start mid-load ignored
    start_load(7'd1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    bus.load_start = 1'b1; bus.load_len = 7'd5;
    send_byte(8'h00, 1'b0);
    bus.load_start = 1'b0;
    chk("rl_cpu_rst", {31'd0, bus.cpu_rst}, 32'd1);
    chk("rl_in_ready", {31'd0, bus.in_ready}, 32'd1);
    send_byte(8'h00, 1'b0);
    chk("rl_done", {31'd0, bus.load_done}, 32'd1);
    vt.push_back('{"rl_pc0", 32'h0, 32'h0});
    vt.push_back('{"rl_pc1", 32'h1, 32'h8C09_0004});
    run_table();

    // Basic back-to-back load from IDLE
    pulse_rst();
    start_load(7'd2);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("bb_not_done", {31'd0, bus.load_done}, 32'd0);
      send_byte(prog[i], 1'b0);
    end
    chk("bb_done", {31'd0, bus.load_done}, 32'd1);
    chk("bb_cpu_rst", {31'd0, bus.cpu_rst}, 32'd0);
    vt.push_back('{"bb_pc0", 32'h0, 32'h2008_0005});
    vt.push_back('{"bb_pc1", 32'h1, 32'h8C09_0004});
    run_table();

    // Reset after 6 of 8 bytes
    start_load(7'd2);
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0); send_byte(8'h66, 1'b0);
    rst = 1'b1;
    #1;
    chk("mr_instr", bus.instr, 32'h0);
    chk("mr_cpu_rst", {31'd0, bus.cpu_rst}, 32'd1);
    chk("mr_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("mr_load_done", {31'd0, bus.load_done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    start_load('0);
    vt.push_back('{"mr_pc0", 32'h0, 32'h1122_3344});
    vt.push_back('{"mr_pc1", 32'h1, 32'h8C09_0004});
    run_table();
    start_load(7'd1);
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0); send_byte(8'hDD, 1'b0);
    chk("mr2_done", {31'd0, bus.load_done}, 32'd1);
    vt.push_back('{"mr2_pc0", 32'h0, 32'hAABB_CCDD});
    vt.push_back('{"mr2_pc1", 32'h1, 32'h8C09_0004});
    run_table();

    // Clamp to DEPTH, no wrap write, alias
    pulse_rst();
    start_load(7'd100);
    for (int i = 0; i < 64; i++) begin
      w = wgen(i);
      if (i == 63) chk("cl_in_ready_63", {31'd0, bus.in_ready}, 32'd1);
      send_byte(w[31:24], 1'b0); send_byte(w[23:16], 1'b0);
      send_byte(w[15:8], 1'b0);  send_byte(w[7:0], 1'b0);
    end
    chk("cl_done", {31'd0, bus.load_done}, 32'd1);
    chk("cl_cpu_rst", {31'd0, bus.cpu_rst}, 32'd0);
    bus.in_valid = 1'b1; bus.in_data = 8'hFF;
    @(posedge clk); #1;
    chk("cl_in_ready_run", {31'd0, bus.in_ready}, 32'd0);
    chk("cl_done_off", {31'd0, bus.load_done}, 32'd0);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 64; i++) vt.push_back('{"cl_word", 32'(i), wgen(i)});
    vt.push_back('{"cl_alias40", 32'h40, wgen(0)});
    vt.push_back('{"cl_alias7f", 32'h7F, wgen(63)});
    run_table();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter AW, default 6, meaning word-address width; memory depth is DEPTH = 2**AW 32-bit words.
REQ-002 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port rst  input  1  reset, asynchronous and active-high.
REQ-004 Port pc  input  32  word address from the datapath (pc increments by 1 per instruction).
REQ-005 Port instr  output  32  instruction word returned for pc.
REQ-006 Port load_start  input  1  single-cycle request to begin a program load.
REQ-007 Port load_len  input  AW+1  number of 32-bit words to load, sampled when load_start is accepted.
REQ-008 Port in_valid  input  1  byte-stream valid.
REQ-009 Port in_data  input  8  byte-stream data.
REQ-010 Port in_ready  output  1  byte-stream ready.
REQ-011 Port cpu_rst  output  1  hold-in-reset for the datapath; high whenever the state is not RUN.
REQ-012 Port load_done  output  1  one-cycle pulse when a load completes.

Function
REQ-013 FSM states: IDLE, LOAD, RUN; after reset the state SHALL be IDLE.
REQ-014 IDLE: load_start=1 -> LOAD, latching len = min(load_len, DEPTH); if load_len=0 -> RUN directly with a load_done pulse.
REQ-015 LOAD: in_ready=1; a byte is accepted on any cycle with in_valid=1 and in_ready=1.
REQ-016 Bytes SHALL be assembled big-endian: 1st byte -> word[31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0].
REQ-017 On acceptance of the 4th byte, the full word SHALL be written to mem[waddr] on that same edge, waddr SHALL increment, and the byte counter SHALL return to 0.
REQ-018 When the written-word count equals len, the state SHALL be RUN on the following edge and load_done SHALL be 1 for exactly that first RUN cycle.
REQ-019 In IDLE and RUN, in_ready=0 and no bytes are consumed.
REQ-020 load_start during LOAD SHALL be ignored (no restart, len unchanged).
REQ-021 load_start in RUN SHALL re-enter LOAD (reload); cpu_rst SHALL rise on the same edge, and waddr and the byte counter SHALL restart at 0.
REQ-022 waddr is AW bits wide; a length of DEPTH fills mem[0..DEPTH-1] with no wrap-around write.
REQ-023 Read: in RUN, instr = mem[pc[AW-1:0]] combinationally (zero latency); pc[31:AW] SHALL be ignored (address aliasing).
REQ-024 Outside RUN, instr = 32'h0000_0000 (NOP).
REQ-025 cpu_rst = 1 in IDLE and LOAD and 0 in RUN, driven from registered state (glitch-free).
REQ-026 Memory contents are not reset; words not rewritten by a load SHALL retain their prior values.

Reset
REQ-027 rst=1 SHALL immediately force: state=IDLE, instr=0, in_ready=0, cpu_rst=1, load_done=0, waddr=0, byte counter=0, latched len=0.
REQ-028 rst asserted mid-LOAD SHALL discard any partial word; words already written stay in memory.
REQ-029 After rst deasserts, no state changes until load_start is asserted.

Verification
REQ-030 Basic load: load_start with load_len=2, bytes 20 08 00 05 8C 09 00 04 streamed back-to-back -> load_done pulses the cycle after the 8th byte; then cpu_rst=0; pc=0 -> instr=32'h2008_0005; pc=1 -> instr=32'h8C09_0004.
REQ-031 Backpressure/gaps: the same stream with in_valid low on alternate cycles -> identical memory image; in_ready stays 1 throughout LOAD.
REQ-032 Zero length: load_start with load_len=0 -> RUN on the next edge, load_done=1 for one cycle, in_ready never 1.
REQ-033 Clamp and alias: AW=6, load_len=100, 64 words streamed -> RUN after word 63; pc=32'h40 -> same instr as pc=0; further in_valid bytes not accepted.
REQ-034 Reset mid-load: rst pulse after 6 of 8 bytes -> instr=0, cpu_rst=1, in_ready=0 immediately; mem[0] retains the first word.
REQ-035 Reload: in RUN, load_start with load_len=1 and bytes 00 00 00 00 -> cpu_rst=1 during the load; mem[0]=0 afterwards and mem[1] unchanged; load_start pulses during LOAD are ignored.
